if_fetch_buf: RTL
=================

Name: if_fetch_buf

Overview:
- Instruction-fetch front end sitting between the PC register and the decode stage.
- Each cycle it issues the current PC to instruction memory over a req/ack handshake that tolerates variable latency.
- It captures the returned word into the IF/ID pipeline register and raises a stall request to the pipeline controller while a fetch is outstanding.
- A one-entry hold buffer absorbs a response that arrives while decode is stalled; a flush discards in-flight and buffered words.

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width
- NOP_INST, 32'h00000000, word driven on id_inst during a bubble

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  controller stall vector; bit1 = IF stage, bit2 = ID stage (1 = stop)
- flush  in  1  redirect; discard everything fetched; wins over stall
- if_pc  in  ADDR_W  current PC
- if_ce  in  1  PC valid / fetch enable
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  ADDR_W  fetch address
- mem_ack  in  1  memory returns mem_rdata this cycle
- mem_rdata  in  DATA_W  fetched word
- stallreq_if  out  1  combinational stall request to the controller
- id_pc  out  ADDR_W  registered PC of the instruction in ID
- id_inst  out  DATA_W  registered instruction word to ID
- id_valid  out  1  id_inst is a real instruction (0 = bubble)

Behaviour:
- Reset (rst=1 at an edge): state=REQ; id_pc=0; id_inst=NOP_INST; id_valid=0; hold buffer invalid; latched address=0. mem_req is 0 while rst=1.
- States: REQ, WAIT, HOLD, DROP.
- REQ:
  - mem_req=if_ce; mem_addr=if_pc.
  - If if_ce=1 and mem_ack=1 in the same cycle (zero-wait), the word is available this cycle and stallreq_if=0.
  - If if_ce=1 and mem_ack=0: stallreq_if=1; latch if_pc; go to WAIT.
  - If if_ce=0: no request; the IF/ID register loads a bubble on the next unstalled edge.
- WAIT:
  - mem_req=1; mem_addr=latched address, held constant until ack.
  - stallreq_if = !mem_ack.
  - On ack with stall[1]=0: load IF/ID, go to REQ.
  - On ack with stall[1]=1: capture into the hold buffer, go to HOLD.
- HOLD:
  - mem_req=0; stallreq_if=0.
  - While stall[1]=1: hold.
  - When stall[1]=0: load IF/ID from the buffer, go to REQ.
- IF/ID register update at each edge, in priority order:
  - flush=1: id_valid=0, id_inst=NOP_INST.
  - else stall[1]=1 and stall[2]=0: bubble, same as flush.
  - else stall[1]=1 and stall[2]=1: hold all id_* outputs.
  - else a word is available (REQ+ack, WAIT+ack, or HOLD): id_pc=its address, id_inst=the word, id_valid=1.
  - else: bubble.
- Flush:
  - In REQ or HOLD: buffer cleared, go to REQ.
  - In WAIT with mem_ack=0: go to DROP.
  - In WAIT with ack in the flush cycle: the word is discarded, go to REQ.
  - The controller guarantees pc_reg loads the redirect target on the flush edge.
- DROP:
  - mem_req=1 at the latched address (memory cannot cancel); stallreq_if=1 until ack.
  - The returned word is discarded; go to REQ. Whatever the memory returns in DROP is never written into id_inst.
- Every id_valid=1 instruction is delivered exactly once, in PC order.
- No ack is ever expected while mem_req=0; an ack in REQ is ignored if if_ce=0.
- Address and data are carried unmodified; no arithmetic beyond width matching.

Decomposition:
- Shared define file (existing header) holds: Stop/NoStop, RstEna, ChipEna/ChipDisa, InstAddrBus/InstBus widths, ZeroWord/NOP constant.
- FSM state encodings are local parameters.
- One natural sub-module: if_id_reg, the IF/ID register with the bubble/hold/load priority above. The FSM and hold buffer stay in the top.

Test Plan:
- Zero-wait memory, if_ce=1, PCs 0,4,8 with ack every cycle -> id_pc follows one cycle later; id_valid=1 continuously; stallreq_if never 1.
- Latency 3, PC=0x10 -> stallreq_if=1 for 3 cycles with mem_addr held at 0x10; then id_pc=0x10 and id_inst=rdata on the edge after ack.
- Ack arrives while stall[1]=1 and stall[2]=1 for 2 cycles -> word parked in HOLD, id_* unchanged, mem_req=0; delivered with id_valid=1 on the first edge with stall[1]=0.
- flush in WAIT (latency 4), then ack returns 0xDEADBEEF -> stallreq_if held until ack; 0xDEADBEEF never appears on id_inst; next fetch uses the new if_pc.
- stall[1]=1, stall[2]=0 for one cycle with a word ready -> exactly one bubble (id_valid=0, id_inst=NOP_INST); the word is delivered on the next edge.
- rst asserted mid-WAIT -> next edge: state REQ, id_valid=0, mem_req=0 while rst=1; a late ack after reset is ignored.

Source files
------------

// File: rtl/if_fetch_buf_pkg.sv
// Shared fetch-stage definitions: control polarities, bus widths, stall-vector
// bit positions and the fetch FSM state type.
package if_fetch_buf_pkg;

    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;
    localparam logic RST_ENA   = 1'b1;
    localparam logic CHIP_ENA  = 1'b1;
    localparam logic CHIP_DISA = 1'b0;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int STALL_W     = 6;
    localparam int STALL_IF    = 1;
    localparam int STALL_ID    = 2;

    localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_buf_id_reg.sv
// IF/ID pipeline register: flush and IF-only stalls insert a bubble, a joint
// IF+ID stall freezes the register, otherwise an available word is loaded.
module if_id_reg
    import if_fetch_buf_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                DATA_W   = INST_W,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(ZERO_WORD)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic [STALL_W-1:0] i_stall,
    input  logic               i_word_valid,
    input  logic [ADDR_W-1:0]  i_word_pc,
    input  logic [DATA_W-1:0]  i_word_inst,
    output logic [ADDR_W-1:0]  o_id_pc,
    output logic [DATA_W-1:0]  o_id_inst,
    output logic               o_id_valid
);

    logic [ADDR_W-1:0] r_id_pc;
    logic [DATA_W-1:0] r_id_inst;
    logic              r_id_valid;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            r_id_pc    <= '0;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end else if (i_flush) begin
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end else if (i_stall[STALL_IF] == STOP && i_stall[STALL_ID] == NO_STOP) begin
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end else if (i_stall[STALL_IF] == STOP) begin
            r_id_pc    <= r_id_pc;
            r_id_inst  <= r_id_inst;
            r_id_valid <= r_id_valid;
        end else if (i_word_valid) begin
            r_id_pc    <= i_word_pc;
            r_id_inst  <= i_word_inst;
            r_id_valid <= 1'b1;
        end else begin
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end
    end

    assign o_id_pc    = r_id_pc;
    assign o_id_inst  = r_id_inst;
    assign o_id_valid = r_id_valid;

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch front end: variable-latency req/ack fetch FSM with a
// one-entry hold buffer, feeding the IF/ID register.
module if_fetch_buf
    import if_fetch_buf_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                DATA_W   = INST_W,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(ZERO_WORD)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  if_pc,
    input  logic               if_ce,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               stallreq_if,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [DATA_W-1:0]  id_inst,
    output logic               id_valid
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_buf_pc;
    logic [DATA_W-1:0] r_buf_inst;
    logic              r_buf_valid;

    logic              w_stall_if;
    logic              w_mem_req;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_stallreq;
    logic              w_word_valid;
    logic [ADDR_W-1:0] w_word_pc;
    logic [DATA_W-1:0] w_word_inst;

    assign w_stall_if = (stall[STALL_IF] == STOP);

    // NOTE: every output gets a default first so no latch can be inferred.
    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_addr   = r_addr;
        w_stallreq   = 1'b0;
        w_word_valid = 1'b0;
        w_word_pc    = r_addr;
        w_word_inst  = mem_rdata;
        case (r_state)
            S_REQ: begin
                w_mem_req    = (if_ce == CHIP_ENA);
                w_mem_addr   = if_pc;
                w_stallreq   = (if_ce == CHIP_ENA) && !mem_ack;
                w_word_valid = (if_ce == CHIP_ENA) && mem_ack;
                w_word_pc    = if_pc;
            end
            S_WAIT: begin
                w_mem_req    = 1'b1;
                w_stallreq   = !mem_ack;
                w_word_valid = mem_ack;
            end
            S_HOLD: begin
                w_word_valid = r_buf_valid;
                w_word_pc    = r_buf_pc;
                w_word_inst  = r_buf_inst;
            end
            S_DROP: begin
                // The memory cannot cancel, so the stale response is drained and dropped.
                w_mem_req    = 1'b1;
                w_stallreq   = !mem_ack;
            end
            default: ;
        endcase
        if (rst == RST_ENA) w_mem_req = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            r_state     <= S_REQ;
            r_addr      <= '0;
            r_buf_valid <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (!flush && if_ce == CHIP_ENA && !mem_ack) begin
                        r_addr  <= if_pc;
                        r_state <= S_WAIT;
                    end
                    r_buf_valid <= 1'b0;
                end
                S_WAIT: begin
                    if (flush) begin
                        r_state <= mem_ack ? S_REQ : S_DROP;
                    end else if (mem_ack && w_stall_if) begin
                        r_buf_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else if (mem_ack) begin
                        r_state <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (flush || !w_stall_if) begin
                        r_buf_valid <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (mem_ack) r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    // NOTE: buffer payload needs no reset; r_buf_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (r_state == S_WAIT && mem_ack && !flush && w_stall_if) begin
            r_buf_pc   <= r_addr;
            r_buf_inst <= mem_rdata;
        end
    end

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (flush),
        .i_stall      (stall),
        .i_word_valid (w_word_valid),
        .i_word_pc    (w_word_pc),
        .i_word_inst  (w_word_inst),
        .o_id_pc      (id_pc),
        .o_id_inst    (id_inst),
        .o_id_valid   (id_valid)
    );

    assign mem_req     = w_mem_req;
    assign mem_addr    = w_mem_addr;
    assign stallreq_if = w_stallreq;

endmodule
